// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, the flush NOP encoding and the
// IF/ID control FSM state type.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    StRun,
    StMcWait
  } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register plus the control that turns load-use stall, EX flush
// and multi-cycle execution requests into PC / IF/ID / ID/EX enables.
module if_id_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic [XLEN-1:0]  if_instruction,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pc_en,
  output logic [XLEN-1:0]  id_instruction,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_valid,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mc_timeout
);

  localparam int unsigned TIMER_W = $clog2(MC_TIMEOUT);

  ctrl_state_e       state_q, state_d;
  logic [XLEN-1:0]   id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic              id_valid_q, id_valid_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic              mc_timeout_q, mc_timeout_d;
  logic              stall_inc, flush_inc;

  always_comb begin
    state_d      = state_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    timer_d      = timer_q;
    mc_timeout_d = mc_timeout_q;
    pc_en        = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    // Enables stay low while reset is held, independent of the inputs.
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (flush_req) begin
            pc_en       = 1'b1;
            id_instr_d  = NOP;
            id_pc_d     = '0;
            id_valid_d  = 1'b0;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
          end else if (mc_start && !mc_done) begin
            idex_hold = 1'b1;
            timer_d   = '0;
            state_d   = StMcWait;
          end else if (stall_req && !mc_start) begin
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            // Normal advance, including a zero-wait multi-cycle op.
            pc_en      = 1'b1;
            id_instr_d = if_instruction;
            id_pc_d    = if_pc;
            id_valid_d = 1'b1;
          end
        end
        StMcWait: begin
          idex_hold = 1'b1;
          timer_d   = timer_q + 1'b1;
          if (mc_done) begin
            state_d = StRun;
          end else if (timer_d == TIMER_W'(MC_TIMEOUT - 1)) begin
            mc_timeout_d = 1'b1;
            state_d      = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      id_instr_q   <= NOP;
      id_pc_q      <= '0;
      id_valid_q   <= 1'b0;
      timer_q      <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      timer_q      <= timer_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign id_instruction = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_valid       = id_valid_q;
  assign mc_timeout     = mc_timeout_q;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Randomized and directed bench for if_id_stall_ctrl against a cycle-level
// behavioural model of the stall/flush/multi-cycle rules.
module tb_if_id_stall_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned MC_TIMEOUT = 8;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             stall_req;
  logic             flush_req;
  logic             mc_start;
  logic             mc_done;
  logic [XLEN-1:0]  if_instruction;
  logic [XLEN-1:0]  if_pc;
  logic             pc_en;
  logic [XLEN-1:0]  id_instruction;
  logic [XLEN-1:0]  id_pc;
  logic             id_valid;
  logic             idex_bubble;
  logic             idex_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mc_timeout;

  if_id_stall_ctrl #(
    .CNT_W      (CNT_W),
    .MC_TIMEOUT (MC_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .flush_req      (flush_req),
    .mc_start       (mc_start),
    .mc_done        (mc_done),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .pc_en          (pc_en),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .idex_bubble    (idex_bubble),
    .idex_hold      (idex_hold),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .mc_timeout     (mc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hold_seen = 0;

  // Model: "waiting" means EX is frozen on a multi-cycle op; held counts the
  // total hold cycles since mc_start, including the start cycle.
  bit              m_wait;
  int              m_held;
  logic [XLEN-1:0] m_instr;
  logic [XLEN-1:0] m_pc;
  bit              m_valid;
  int              m_stall;
  int              m_flush;
  bit              m_tout;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_held  = 0;
    m_instr = NOP;
    m_pc    = '0;
    m_valid = 1'b0;
    m_stall = 0;
    m_flush = 0;
    m_tout  = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    check_eq({pfx, "_id_instruction"}, id_instruction, m_instr);
    check_eq({pfx, "_id_pc"}, id_pc, m_pc);
    check_eq({pfx, "_id_valid"}, id_valid, m_valid);
    check_eq({pfx, "_stall_count"}, stall_count, m_stall);
    check_eq({pfx, "_flush_count"}, flush_count, m_flush);
    check_eq({pfx, "_mc_timeout"}, mc_timeout, m_tout);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit st, input bit fl, input bit ms, input bit md,
                      input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
    bit e_pc_en, e_bub, e_hold;
    stall_req      = st;
    flush_req      = fl;
    mc_start       = ms;
    mc_done        = md;
    if_instruction = instr;
    if_pc          = pc;
    #1;
    e_pc_en = 1'b0;
    e_bub   = 1'b0;
    e_hold  = 1'b0;
    if (m_wait) e_hold = 1'b1;
    else if (fl) begin e_pc_en = 1'b1; e_bub = 1'b1; end
    else if (ms && !md) e_hold = 1'b1;
    else if (st && !ms) e_bub = 1'b1;
    else e_pc_en = 1'b1;
    check_eq("pc_en", pc_en, e_pc_en);
    check_eq("idex_bubble", idex_bubble, e_bub);
    check_eq("idex_hold", idex_hold, e_hold);
    check_regs("cyc");
    if (idex_hold) hold_seen++;

    if (m_wait) begin
      if (md) m_wait = 1'b0;
      else begin
        m_held++;
        if (m_held == MC_TIMEOUT) begin
          m_tout = 1'b1;
          m_wait = 1'b0;
        end
      end
    end else if (fl) begin
      m_instr = NOP;
      m_pc    = '0;
      m_valid = 1'b0;
      if (m_flush < CNT_MAX) m_flush++;
    end else if (ms && !md) begin
      m_wait = 1'b1;
      m_held = 1;
    end else if (st && !ms) begin
      if (m_stall < CNT_MAX) m_stall++;
    end else begin
      m_instr = instr;
      m_pc    = pc;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [XLEN-1:0] pc);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, pc);
  endtask

  int base_stall;

  initial begin
    rst = 1'b1;
    stall_req = 1'b0;
    flush_req = 1'b0;
    mc_start  = 1'b0;
    mc_done   = 1'b0;
    if_instruction = '0;
    if_pc = '0;
    model_reset();

    // Reset values while rst is held, with requests active.
    stall_req = 1'b1;
    flush_req = 1'b1;
    #2;
    check_eq("rst_pc_en", pc_en, 1'b0);
    check_eq("rst_bubble", idex_bubble, 1'b0);
    check_eq("rst_hold", idex_hold, 1'b0);
    check_regs("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch stream.
    idle(32'd0);
    check_eq("stream_pc0", id_pc, 32'd0);
    check_eq("stream_valid", id_valid, 1'b1);
    idle(32'd4);
    // Load-use stall at id_pc=4.
    step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, 32'd8);
    check_eq("stall_pc_hold", id_pc, 32'd4);
    check_eq("stall_count1", stall_count, 16'd1);
    idle(32'd8);
    check_eq("stall_resume", id_pc, 32'd8);

    // Flush beats stall and mc_start.
    step(1'b1, 1'b1, 1'b1, 1'b0, $urandom, 32'd12);
    check_eq("flush_nop", id_instruction, NOP);
    check_eq("flush_valid", id_valid, 1'b0);
    check_eq("flush_count1", flush_count, 16'd1);
    check_eq("flush_stall_ign", stall_count, 16'd1);
    idle(32'd16);
    check_eq("flush_run_pc", id_pc, 32'd16);

    // Multi-cycle op, done 5 cycles after start; stall pulses ignored.
    base_stall = m_stall;
    hold_seen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'd20);
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0, 1'b0, $urandom, 32'd20);
    step(1'b1, 1'b0, 1'b0, 1'b1, $urandom, 32'd20);
    check_eq("mc_hold_cycles", hold_seen, 6);
    check_eq("mc_stall_unch", stall_count, base_stall);
    idle(32'd20);
    check_eq("mc_resume_pc", id_pc, 32'd20);

    // Watchdog: no mc_done.
    hold_seen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'd24);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'd24);
    check_eq("tout_hold_cycles", hold_seen, 8);
    check_eq("tout_flag", mc_timeout, 1'b1);
    idle(32'd28);
    check_eq("tout_run_pc", id_pc, 32'd28);
    check_eq("tout_sticky", mc_timeout, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom);
    end

    // Reset in the middle of a multi-cycle wait, checked before any edge.
    step(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 32'd40);
    step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd40);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst_pc_en", pc_en, 1'b0);
    check_eq("arst_hold", idex_hold, 1'b0);
    check_eq("arst_bubble", idex_bubble, 1'b0);
    check_regs("arst");
    @(negedge clk);
    rst = 1'b0;
    idle(32'd44);
    check_eq("arst_run_pc", id_pc, 32'd44);

    // Drive stall_count to saturation and beyond.
    for (int i = 0; i < CNT_MAX + 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, 32'd48);
    check_eq("stall_sat", stall_count, 16'hFFFF);
    check_eq("sat_pc_hold", id_pc, 32'd44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
